// File: rtl/ball_motion_engine_if.sv
// Ball motion engine port bundle: game-state/paddle inputs, ball outputs.
interface ball_motion_engine_if;
  logic [1:0] game_state;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_right;
  logic       p1_hit;
  logic       p2_hit;
  logic       wall_hit;

  modport master (
    output game_state, p1_y, p2_y,
    input  ball_x, ball_y, dir_right,
    input  p1_hit, p2_hit, wall_hit
  );

  modport slave (
    input  game_state, p1_y, p2_y,
    output ball_x, ball_y, dir_right,
    output p1_hit, p2_hit, wall_hit
  );
endinterface

// File: rtl/ball_motion_engine.sv
// Ball position generator: serve parking, prescaled motion, wall/paddle bounce.
// Optional SPEEDUP_EN: speed rises by 1 every 4 paddle hits up to MAX_SPEED.
module ball_motion_engine #(
  parameter int TICK_DIV   = 500000,
  parameter int P1_BOARD_X = 150,
  parameter int P2_BOARD_X = 490,
  parameter int PADDLE_W   = 4,
  parameter int PADDLE_H   = 48,
  parameter int Y_MIN      = 40,
  parameter int Y_MAX      = 440,
  parameter int X_LIMIT    = 639,
  parameter int INIT_SPEED = 2,
  parameter int VY_STEP    = 1,
  parameter int MAX_SPEED  = 6
) (
  input logic clk,
  input logic reset,
  ball_motion_engine_if.slave bus
);

  typedef enum logic [1:0] {
    P1_SERVE = 2'd0,
    P2_SERVE = 2'd1,
    PLAYING  = 2'd2,
    GAME_END = 2'd3
  } mode_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Serve speed never exceeds the ceiling.
  localparam int SPD0 =
    (INIT_SPEED > MAX_SPEED) ? MAX_SPEED : INIT_SPEED;

  localparam logic [10:0] L_P1X  = 11'(P1_BOARD_X);
  localparam logic [10:0] L_P2X  = 11'(P2_BOARD_X);
  localparam logic [10:0] L_PW   = 11'(PADDLE_W);
  localparam logic [10:0] L_PH   = 11'(PADDLE_H);
  localparam logic [10:0] L_YMIN = 11'(Y_MIN);
  localparam logic [10:0] L_YMAX = 11'(Y_MAX);
  localparam logic [10:0] L_XLIM = 11'(X_LIMIT);
  localparam logic [10:0] L_VY   = 11'(VY_STEP);
  localparam logic [9:0]  P1_PARK = 10'(P1_BOARD_X + PADDLE_W + 1);
  localparam logic [9:0]  P2_PARK = 10'(P2_BOARD_X - PADDLE_W - 1);
  localparam logic [9:0]  HALF_H  = 10'(PADDLE_H / 2);

  mode_t mode;
  assign mode = mode_t'(bus.game_state);

  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          right_q, right_d;
  logic          down_q, down_d;
  logic          p1h_q, p1h_d;
  logic          p2h_q, p2h_d;
  logic          wh_q, wh_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    speed;

`ifdef SPEEDUP_EN
  logic [9:0] speed_q, speed_d;
  logic [1:0] hc_q, hc_d;
  assign speed = speed_q;
`else
  assign speed = 10'(SPD0);
`endif

  logic [10:0] bx, by, sp, p1t, p2t;
  logic        in_p1, in_p2, tick;

  assign bx    = {1'b0, x_q};
  assign by    = {1'b0, y_q};
  assign sp    = {1'b0, speed};
  assign p1t   = {1'b0, bus.p1_y};
  assign p2t   = {1'b0, bus.p2_y};
  assign in_p1 = (by >= p1t) && (by < p1t + L_PH);
  assign in_p2 = (by >= p2t) && (by < p2t + L_PH);
  assign tick  = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    right_d = right_q;
    down_d  = down_q;
    p1h_d   = 1'b0;
    p2h_d   = 1'b0;
    wh_d    = 1'b0;
    presc_d = '0;
`ifdef SPEEDUP_EN
    speed_d = speed_q;
    hc_d    = hc_q;
`endif
    unique case (mode)
      P1_SERVE: begin
        x_d     = P1_PARK;
        y_d     = bus.p1_y + HALF_H;
        right_d = 1'b1;
        down_d  = 1'b1;
      end
      P2_SERVE: begin
        x_d     = P2_PARK;
        y_d     = bus.p2_y + HALF_H;
        right_d = 1'b0;
        down_d  = 1'b0;
      end
      PLAYING: begin
        if (!tick) begin
          presc_d = presc_q + 1'b1;
        end else begin
          // A ball already behind a paddle slips through to be scored.
          if (!right_q) begin
            if (bx > L_P1X && bx <= L_P1X + L_PW + sp && in_p1) begin
              x_d     = 10'(L_P1X + L_PW);
              right_d = 1'b1;
              p1h_d   = 1'b1;
            end else if (bx < sp) begin
              x_d = '0;
            end else begin
              x_d = x_q - speed;
            end
          end else begin
            if (bx < L_P2X && bx + sp >= L_P2X - L_PW && in_p2) begin
              x_d     = 10'(L_P2X - L_PW);
              right_d = 1'b0;
              p2h_d   = 1'b1;
            end else if (bx + sp > L_XLIM) begin
              x_d = 10'(L_XLIM);
            end else begin
              x_d = 10'(bx + sp);
            end
          end
          if (down_q) begin
            if (by + L_VY >= L_YMAX) begin
              y_d    = 10'(L_YMAX);
              down_d = 1'b0;
              wh_d   = 1'b1;
            end else begin
              y_d = 10'(by + L_VY);
            end
          end else begin
            if (by <= L_YMIN + L_VY) begin
              y_d    = 10'(L_YMIN);
              down_d = 1'b1;
              wh_d   = 1'b1;
            end else begin
              y_d = 10'(by - L_VY);
            end
          end
        end
      end
      GAME_END: begin
      end
      default: begin
      end
    endcase
`ifdef SPEEDUP_EN
    if (mode == P1_SERVE || mode == P2_SERVE) begin
      speed_d = 10'(SPD0);
      hc_d    = '0;
    end else if (p1h_d || p2h_d) begin
      hc_d = hc_q + 2'd1;
      if (hc_q == 2'd3 && speed_q < 10'(MAX_SPEED))
        speed_d = speed_q + 10'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= P1_PARK;
      y_q     <= 10'd240;
      right_q <= 1'b1;
      down_q  <= 1'b1;
      p1h_q   <= 1'b0;
      p2h_q   <= 1'b0;
      wh_q    <= 1'b0;
      presc_q <= '0;
`ifdef SPEEDUP_EN
      speed_q <= 10'(SPD0);
      hc_q    <= '0;
`endif
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      right_q <= right_d;
      down_q  <= down_d;
      p1h_q   <= p1h_d;
      p2h_q   <= p2h_d;
      wh_q    <= wh_d;
      presc_q <= presc_d;
`ifdef SPEEDUP_EN
      speed_q <= speed_d;
      hc_q    <= hc_d;
`endif
    end
  end

  assign bus.ball_x    = x_q;
  assign bus.ball_y    = y_q;
  assign bus.dir_right = right_q;
  assign bus.p1_hit    = p1h_q;
  assign bus.p2_hit    = p2h_q;
  assign bus.wall_hit  = wh_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine with TICK_DIV=4.
module tb_ball_motion_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   fails = 0;

  ball_motion_engine_if bmi();

  ball_motion_engine #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bmi)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pulses();
    return {bmi.p1_hit, bmi.p2_hit, bmi.wall_hit};
  endfunction

  initial begin
    bmi.game_state = 2'd0;
    bmi.p1_y = 10'd100;
    bmi.p2_y = 10'd0;
    tick(2);
    check("rst_x", bmi.ball_x, 155);
    check("rst_y", bmi.ball_y, 240);
    check("rst_dir", bmi.dir_right, 1);
    check("rst_pulse", pulses(), 0);

    reset = 1'b0;
    tick(1);
    check("srv1_x", bmi.ball_x, 155);
    check("srv1_y", bmi.ball_y, 124);
    bmi.p1_y = 10'd200;
    tick(1);
    check("srv1_track", bmi.ball_y, 224);
    bmi.p1_y = 10'd100;
    tick(1);

    bmi.game_state = 2'd2;
    tick(3);
    check("play_wait", bmi.ball_x, 155);
    tick(1);
    check("play1_x", bmi.ball_x, 157);
    check("play1_y", bmi.ball_y, 125);
    check("play1_pulse", pulses(), 0);
    tick(4);
    check("play2_x", bmi.ball_x, 159);
    check("play2_y", bmi.ball_y, 126);

    bmi.game_state = 2'd1;
    bmi.p2_y = 10'd0;
    tick(1);
    check("srv2_x", bmi.ball_x, 485);
    check("srv2_y", bmi.ball_y, 24);
    check("srv2_dir", bmi.dir_right, 0);
    bmi.game_state = 2'd2;
    tick(4);
    check("wall_y", bmi.ball_y, 40);
    check("wall_pulse", pulses(), 3'b001);
    check("wall_x", bmi.ball_x, 483);
    tick(1);
    check("wall_clr", pulses(), 0);
    tick(3);
    check("wall_y2", bmi.ball_y, 41);
    check("wall_x2", bmi.ball_x, 481);

    bmi.game_state = 2'd0;
    tick(1);
    bmi.p2_y = 10'd270;
    bmi.game_state = 2'd2;
    tick(660);
    check("p2_pre_x", bmi.ball_x, 485);
    check("p2_pre_y", bmi.ball_y, 289);
    tick(4);
    check("p2_hit_x", bmi.ball_x, 486);
    check("p2_hit_dir", bmi.dir_right, 0);
    check("p2_hit_pulse", pulses(), 3'b010);
    tick(1);
    check("p2_hit_clr", pulses(), 0);
    tick(3);
    check("p2_back_x", bmi.ball_x, 484);
    check("p2_back_y", bmi.ball_y, 291);

    bmi.game_state = 2'd0;
    tick(1);
    bmi.p2_y = 10'd300;
    bmi.game_state = 2'd2;
    tick(664);
    check("miss_x", bmi.ball_x, 487);
    check("miss_dir", bmi.dir_right, 1);
    check("miss_pulse", pulses(), 0);
    tick(304);
    check("sat_x", bmi.ball_x, 639);
    tick(4);
    check("sat_hold", bmi.ball_x, 639);
    check("sat_y", bmi.ball_y, 367);

    tick(3);
    bmi.game_state = 2'd1;
    bmi.p2_y = 10'd100;
    tick(1);
    check("prio_x", bmi.ball_x, 485);
    check("prio_y", bmi.ball_y, 124);
    check("prio_pulse", pulses(), 0);
    bmi.game_state = 2'd3;
    tick(100);
    check("end_x", bmi.ball_x, 485);
    check("end_y", bmi.ball_y, 124);
    bmi.game_state = 2'd2;
    tick(3);
    check("resume_wait", bmi.ball_x, 485);
    tick(1);
    check("resume_x", bmi.ball_x, 483);
    check("resume_y", bmi.ball_y, 123);

    reset = 1'b1;
    tick(1);
    check("mid_rst_x", bmi.ball_x, 155);
    check("mid_rst_y", bmi.ball_y, 240);
    check("mid_rst_dir", bmi.dir_right, 1);
    reset = 1'b0;

`ifdef SPEEDUP_EN
    begin
      int hits;
      hits = 0;
      bmi.game_state = 2'd0;
      bmi.p1_y = 10'd100;
      tick(1);
      bmi.game_state = 2'd2;
      for (int i = 0; i < 4000 && hits < 4; i++) begin
        bmi.p1_y = bmi.ball_y - 10'd10;
        bmi.p2_y = bmi.ball_y - 10'd10;
        tick(1);
        if (bmi.p1_hit || bmi.p2_hit) hits++;
      end
      check("spd_hits", hits, 4);
      check("spd_hit_x", bmi.ball_x, 154);
      tick(4);
      check("spd_fast_x", bmi.ball_x, 157);
      bmi.game_state = 2'd0;
      tick(1);
      bmi.game_state = 2'd2;
      tick(4);
      check("spd_reserve_x", bmi.ball_x, 157);
    end
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Generates ball position (ball_x, ball_y) for the pingpong game; the producer side of the position/state loop.
- Reads the 2-bit game_state from the game-state FSM and drives ball_x/ball_y back into it.
- Parks the ball on the serving paddle, moves it on a prescaled tick during play, bounces it off top/bottom walls and paddles, and freezes it at game end.
- Misses are not detected here: the ball passes a paddle and the game-state FSM scores on ball_x.

Parameters:
- TICK_DIV, 500000: clk cycles per motion step (100 Hz at 50 MHz).
- P1_BOARD_X, 150: p1 paddle x.
- P2_BOARD_X, 490: p2 paddle x.
- PADDLE_W, 4: paddle thickness in px.
- PADDLE_H, 48: paddle height in px.
- Y_MIN, 40: top wall y.
- Y_MAX, 440: bottom wall y.
- X_LIMIT, 639: max ball_x.
- INIT_SPEED, 2: horizontal px/step after each serve.
- VY_STEP, 1: vertical px/step.
- MAX_SPEED, 6: speed ceiling; used only with SPEEDUP_EN.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- game_state, in, 2: 0 = p1_serve, 1 = p2_serve, 2 = playing, 3 = game_end.
- p1_y, in, 10: p1 paddle top y.
- p2_y, in, 10: p2 paddle top y.
- ball_x, out, 10: ball x.
- ball_y, out, 10: ball y.
- dir_right, out, 1: 1 = ball moving +x.
- p1_hit, out, 1: one-clk pulse on p1 paddle bounce.
- p2_hit, out, 1: one-clk pulse on p2 paddle bounce.
- wall_hit, out, 1: one-clk pulse on wall bounce.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: ball_x = P1_BOARD_X+PADDLE_W+1 (155), ball_y = 240, dir_right = 1, dir_down = 1, speed = INIT_SPEED, hit_cnt = 0, prescaler = 0, all pulses 0. Reset mid-play takes effect on the next edge and overrides everything.
- Internal mode follows game_state each clk; no extra handshake.
- p1_serve (0):
  - ball_x = 155; ball_y = p1_y + PADDLE_H/2, registered (1-clk latency).
  - dir_right = 1, dir_down = 1, speed = INIT_SPEED, prescaler = 0.
- p2_serve (1):
  - ball_x = P2_BOARD_X-PADDLE_W-1 (485); ball_y = p2_y + PADDLE_H/2.
  - dir_right = 0, dir_down = 0, speed = INIT_SPEED, prescaler = 0.
- playing (2):
  - Prescaler counts 0..TICK_DIV-1. The step fires on the clk where count = TICK_DIV-1. First step occurs TICK_DIV clks after entering playing.
  - X step, moving left:
    - Paddle hit when ball_x > P1_BOARD_X, ball_x - speed <= P1_BOARD_X+PADDLE_W, and p1_y <= ball_y < p1_y+PADDLE_H. Result: ball_x = P1_BOARD_X+PADDLE_W, dir_right = 1, p1_hit = 1.
    - Otherwise ball_x -= speed, saturating at 0.
  - X step, moving right (mirror):
    - Paddle hit when ball_x < P2_BOARD_X, ball_x + speed >= P2_BOARD_X-PADDLE_W, and ball_y is within the p2 paddle. Result: ball_x = P2_BOARD_X-PADDLE_W, dir_right = 0, p2_hit = 1.
    - Otherwise ball_x += speed, saturating at X_LIMIT.
  - Y step, moving down: if ball_y+VY_STEP >= Y_MAX, then ball_y = Y_MAX, dir_down = 0, wall_hit = 1; else ball_y += VY_STEP.
  - Y step, moving up: if ball_y <= Y_MIN+VY_STEP, then ball_y = Y_MIN, dir_down = 1, wall_hit = 1; else ball_y -= VY_STEP.
  - The y check uses pre-step ball_y. A paddle and a wall bounce in the same step are both applied; both pulses assert.
  - A ball already past a paddle (ball_x <= P1_BOARD_X or >= P2_BOARD_X) never bounces.
- game_end (3): all position and direction registers hold; prescaler held at 0; no pulses.
- Transition out of playing on the same clk as a step: the serve branch has priority and no step is applied.
- Pulses are exactly 1 clk wide and deassert on the next clk.

Optional Feature:
- Macro: SPEEDUP_EN.
- Defined:
  - 2-bit hit_cnt increments on each p1_hit/p2_hit.
  - On the wrap 3->0, speed increments by 1, saturating at MAX_SPEED.
  - hit_cnt and speed clear on any serve state or reset.
- Undefined: speed is constant INIT_SPEED; no hit_cnt register.

Test Plan:
- Reset and serve tracking (TICK_DIV=4): reset held 2 clks with game_state=0, p1_y=100 -> ball_x=155, ball_y=124 one clk after release, all pulses 0. Then p1_y=200 -> ball_y=224 next clk.
- Play from p1 serve: game_state 0->2, p1_y=100 -> ball_x=157, ball_y=125 on the 4th clk in playing; 159/126 after 4 more clks. No pulse.
- Wall bounce: p2 serve with p2_y=410 (ball_y=434), then play -> ball_y steps up to 433... 40 is not reached; use p2_y=0 (ball_y=24 < Y_MIN). The first step clamps ball_y=40 with wall_hit=1 for 1 clk, dir_down=1, and the next step gives ball_y=41.
- P2 paddle hit: ball moving right near x=482, p2_y aligned with ball_y -> ball_x=486, dir_right=0, p2_hit=1 for exactly 1 clk. With p2_y=300 (misaligned) -> no hit, ball_x passes 490 and continues to X_LIMIT saturation.
- State priority: game_state 2->1 on the step clk -> ball_x=485 the next clk, no step applied, no pulse. Then game_state=3 -> position holds for 100 clks.
- SPEEDUP_EN: force 4 consecutive paddle hits -> speed 2->3 after the 4th, observed as a 3-px x delta on the next step. Re-serve -> speed back to 2.
